// File: rtl/sdio_dat_pkg.sv
// sdio_dat_pkg: shared types and constants for the SDIO 1-bit DAT sequencer.
// States, completion status codes and line-stage phase encodings.
package sdio_dat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_LOAD,
    S_TX_START,
    S_TX_DATA,
    S_TX_CRC,
    S_TX_END,
    S_RX_WAIT,
    S_RX_DATA,
    S_RX_CRC,
    S_RX_END
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_CRC = 2'b01;
  localparam logic [1:0] ST_END = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  localparam logic [1:0] DAT_PH_LOW  = 2'b00;
  localparam logic [1:0] DAT_PH_HIGH = 2'b01;
  localparam logic [1:0] DAT_PH_DATA = 2'b10;
  localparam logic [1:0] DAT_PH_CRC  = 2'b11;

  function automatic logic is_rx(state_t s);
    return (s == S_RX_WAIT) || (s == S_RX_DATA) ||
           (s == S_RX_CRC)  || (s == S_RX_END);
  endfunction

endpackage

// File: rtl/sdio_dat_shift.sv
// sdio_dat_shift: byte serializer (dibit out, MSB first) and
// deserializer (MSB-first capture) sharing one 3-bit bit counter.
module sdio_dat_shift
  import sdio_dat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic       din,
  output logic       last_bit,
  output logic       data_sel,
  output logic [1:0] xmit_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  logic [7:0] sh;
  logic [7:0] cap;
  logic [2:0] bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      cap      <= '0;
      bcnt     <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (tx_en || rx_en) bcnt <= bcnt + 3'd1;
      else                bcnt <= '0;
      // A load on the last bit of a byte takes priority over shifting.
      if (load)
        sh <= load_byte;
      else if (tx_en && bcnt[0])
        sh <= {sh[5:0], 2'b00};
      else if (rx_en)
        sh <= {sh[6:0], din};
      if (rx_en && last_bit) begin
        cap      <= {sh[6:0], din};
        rx_valid <= 1'b1;
      end
    end
  end

  assign last_bit  = (bcnt == 3'd7);
  assign data_sel  = tx_en & bcnt[0];
  assign xmit_data = tx_en ? sh[7:6] : 2'b00;
  assign rx_byte   = rx_valid ? cap : 8'h00;

endmodule

// File: rtl/sdio_dat_seq.sv
// sdio_dat_seq: 1-bit SDIO data-block sequencer (TX/RX framing, CRC phases).
// Optional RX start-bit timeout: define SDIO_DAT_SEQ_RX_TIMEOUT_EN.
module sdio_dat_seq
  import sdio_dat_pkg::*;
#(
  parameter int BLK_LEN_W    = 10,
  parameter int RX_TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic                 rx_start,
  input  logic                 abort,
  input  logic [BLK_LEN_W-1:0] block_len,
  input  logic [7:0]           tx_byte,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [7:0]           rx_byte,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic                 oe,
  output logic                 data_sel,
  output logic                 crc_rst,
  output logic                 crc_check_en,
  output logic [1:0]           dat_phase,
  output logic [1:0]           xmit_data,
  input  logic [1:0]           rcv_data,
  input  logic                 crc_error
);

  localparam logic [BLK_LEN_W-1:0] ONE = BLK_LEN_W'(1);

  state_t               state, nxt;
  logic [BLK_LEN_W-1:0] byte_cnt;
  logic [3:0]           crc_cnt;
  logic                 crc_hold;
  logic                 fin;
  logic [1:0]           fin_st;
  logic                 load, tx_en, rx_en, last_bit;
  logic                 rcv_unused;

  assign rcv_unused = rcv_data[1];

`ifdef SDIO_DAT_SEQ_RX_TIMEOUT_EN
  localparam logic [RX_TIMEOUT_W-1:0] TMO_LAST =
    {{(RX_TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [RX_TIMEOUT_W-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tcnt <= '0;
    else if (state == S_RX_WAIT) tcnt <= tcnt + 1'b1;
    else                        tcnt <= '0;
  end
`else
  localparam int unused_tmo_w = RX_TIMEOUT_W;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      crc_cnt  <= '0;
      crc_hold <= 1'b0;
      done     <= 1'b0;
      status   <= ST_OK;
    end else begin
      state    <= nxt;
      done     <= fin;
      crc_hold <= fin & is_rx(state);
      if (fin) status <= fin_st;
      if (state == S_IDLE)
        byte_cnt <= block_len;
      else if ((tx_en || rx_en) && last_bit)
        byte_cnt <= byte_cnt - ONE;
      if (state == S_TX_CRC || state == S_RX_CRC)
        crc_cnt <= crc_cnt + 4'd1;
      else
        crc_cnt <= '0;
    end
  end

  always_comb begin
    nxt       = state;
    fin       = 1'b0;
    fin_st    = ST_OK;
    tx_ready  = 1'b0;
    oe        = 1'b0;
    crc_rst   = 1'b0;
    dat_phase = DAT_PH_LOW;
    load      = 1'b0;
    tx_en     = 1'b0;
    rx_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // The done cycle is still IDLE; a start there is dropped.
        if (!done && block_len != '0) begin
          if (tx_start)      nxt = S_TX_LOAD;
          else if (rx_start) nxt = S_RX_WAIT;
        end
      end
      S_TX_LOAD: begin
        crc_rst  = 1'b1;
        tx_ready = 1'b1;
        if (tx_valid) begin
          load = 1'b1;
          nxt  = S_TX_START;
        end
      end
      S_TX_START: begin
        oe  = 1'b1;
        nxt = S_TX_DATA;
      end
      S_TX_DATA: begin
        oe        = 1'b1;
        dat_phase = DAT_PH_DATA;
        tx_en     = 1'b1;
        if (last_bit) begin
          if (byte_cnt == ONE) begin
            nxt = S_TX_CRC;
          end else begin
            tx_ready = 1'b1;
            if (tx_valid) begin
              load = 1'b1;
            end else begin
              nxt    = S_IDLE;
              fin    = 1'b1;
              fin_st = ST_TMO;
            end
          end
        end
      end
      S_TX_CRC: begin
        oe        = 1'b1;
        dat_phase = DAT_PH_CRC;
        if (crc_cnt == 4'd15) nxt = S_TX_END;
      end
      S_TX_END: begin
        oe        = 1'b1;
        dat_phase = DAT_PH_HIGH;
        nxt       = S_IDLE;
        fin       = 1'b1;
      end
      S_RX_WAIT: begin
        crc_rst = 1'b1;
        if (!rcv_data[0]) begin
          nxt = S_RX_DATA;
        end
`ifdef SDIO_DAT_SEQ_RX_TIMEOUT_EN
        else if (tcnt == TMO_LAST) begin
          nxt    = S_IDLE;
          fin    = 1'b1;
          fin_st = ST_TMO;
        end
`endif
      end
      S_RX_DATA: begin
        dat_phase = DAT_PH_DATA;
        rx_en     = 1'b1;
        if (last_bit && byte_cnt == ONE) nxt = S_RX_CRC;
      end
      S_RX_CRC: begin
        dat_phase = DAT_PH_CRC;
        if (crc_cnt == 4'd15) nxt = S_RX_END;
      end
      S_RX_END: begin
        dat_phase = DAT_PH_HIGH;
        nxt       = S_IDLE;
        fin       = 1'b1;
        if (crc_error)         fin_st = ST_CRC;
        else if (!rcv_data[0]) fin_st = ST_END;
      end
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      nxt    = S_IDLE;
      fin    = 1'b1;
      fin_st = ST_TMO;
      load   = 1'b0;
    end
  end

  assign busy         = (state != S_IDLE);
  assign crc_check_en = is_rx(state) | crc_hold;

  sdio_dat_shift u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_byte (tx_byte),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .din       (rcv_data[0]),
    .last_bit  (last_bit),
    .data_sel  (data_sel),
    .xmit_data (xmit_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid)
  );

endmodule

// File: tb/tb_sdio_dat_seq.sv
// tb_sdio_dat_seq: directed self-checking bench for sdio_dat_seq.
// Honors SDIO_DAT_SEQ_RX_TIMEOUT_EN for the RX start-bit wait test.
module tb_sdio_dat_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start, rx_start, abort;
  logic [9:0] block_len;
  logic [7:0] tx_byte;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid, busy, done;
  logic [1:0] status;
  logic       oe, data_sel, crc_rst, crc_check_en;
  logic [1:0] dat_phase, xmit_data, rcv_data;
  logic       crc_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdio_dat_seq #(.BLK_LEN_W(10), .RX_TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .tx_start(tx_start), .rx_start(rx_start), .abort(abort),
    .block_len(block_len), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .busy(busy), .done(done), .status(status),
    .oe(oe), .data_sel(data_sel), .crc_rst(crc_rst),
    .crc_check_en(crc_check_en), .dat_phase(dat_phase),
    .xmit_data(xmit_data), .rcv_data(rcv_data),
    .crc_error(crc_error)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rx(input logic [7:0] b, input logic cerr,
                        input logic end_bit, input logic [1:0] exp_st);
    block_len = 10'd1;
    rcv_data  = 2'b11;
    rx_start  = 1'b1;
    tick();
    rx_start = 1'b0;
    chk("rx_wait_busy", busy, 1);
    chk("rx_wait_crc_rst", crc_rst, 1);
    chk("rx_wait_chk_en", crc_check_en, 1);
    chk("rx_wait_oe", oe, 0);
    tick();
    chk("rx_wait_hold", dat_phase, 2'b00);
    rcv_data = 2'b10;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("rx_data_ph", dat_phase, 2'b10);
      chk("rx_data_oe", oe, 0);
      chk("rx_data_crc_rst", crc_rst, 0);
      rcv_data = {rcv_data[0], b[7-i]};
      tick();
    end
    chk("rx_valid", rx_valid, 1);
    chk("rx_byte", rx_byte, b);
    for (int i = 0; i < 16; i++) begin
      chk("rx_crc_ph", dat_phase, 2'b11);
      if (i > 0) chk("rx_valid_once", rx_valid, 0);
      rcv_data  = {rcv_data[0], i[0]};
      if (i >= 8) crc_error = cerr;
      tick();
    end
    chk("rx_end_busy", busy, 1);
    chk("rx_end_done", done, 0);
    rcv_data = {rcv_data[0], end_bit};
    tick();
    chk("rx_done", done, 1);
    chk("rx_status", status, exp_st);
    chk("rx_done_chk_en", crc_check_en, 1);
    chk("rx_done_busy", busy, 0);
    crc_error = 1'b0;
    rcv_data  = 2'b11;
    tick();
    chk("rx_after_done", done, 0);
    chk("rx_after_chk_en", crc_check_en, 0);
    chk("rx_status_hold", status, exp_st);
  endtask

  initial begin
    logic [7:0] txb;
    rst = 1'b1;
    tx_start = 0; rx_start = 0; abort = 0;
    block_len = '0; tx_byte = '0; tx_valid = 0;
    rcv_data = 2'b11; crc_error = 0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 2'b00);
    chk("rst_oe", oe, 0);
    chk("rst_ph", dat_phase, 2'b00);
    chk("rst_ready", tx_ready, 0);
    chk("rst_crc_rst", crc_rst, 0);
    rst = 1'b0;
    tick();

    // TX len=1, 0xA5
    txb = 8'hA5;
    block_len = 10'd1; tx_byte = txb; tx_valid = 1;
    tx_start = 1;
    tick();
    tx_start = 0;
    chk("tx_load_busy", busy, 1);
    chk("tx_load_ready", tx_ready, 1);
    chk("tx_load_crc_rst", crc_rst, 1);
    chk("tx_load_oe", oe, 0);
    tick();
    tx_valid = 0;
    chk("tx_start_oe", oe, 1);
    chk("tx_start_ph", dat_phase, 2'b00);
    chk("tx_start_crc_rst", crc_rst, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tx_data_ph", dat_phase, 2'b10);
      chk("tx_data_oe", oe, 1);
      chk("tx_data_sel", data_sel, i[0]);
      chk("tx_bit", data_sel ? xmit_data[0] : xmit_data[1], txb[7-i]);
      chk("tx_ready_last", tx_ready, 0);
    end
    chk("tx_dibit3", xmit_data, 2'b01);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("tx_crc_ph", dat_phase, 2'b11);
      chk("tx_crc_oe", oe, 1);
    end
    tick();
    chk("tx_end_ph", dat_phase, 2'b01);
    chk("tx_end_oe", oe, 1);
    chk("tx_end_done", done, 0);
    tick();
    chk("tx_done", done, 1);
    chk("tx_status", status, 2'b00);
    chk("tx_done_oe", oe, 0);
    chk("tx_done_busy", busy, 0);
    tx_start = 1;
    tick();
    tx_start = 0;
    chk("start_in_done_ignored", busy, 0);
    chk("done_one_cycle", done, 0);

    // zero-length start ignored
    block_len = 10'd0;
    rx_start = 1;
    tick();
    rx_start = 0;
    chk("len0_ignored", busy, 0);

    run_rx(8'h3C, 1'b0, 1'b1, 2'b00);
    run_rx(8'h96, 1'b1, 1'b1, 2'b01);
    run_rx(8'h3C, 1'b0, 1'b0, 2'b10);

    // TX len=2 underrun after byte 0
    block_len = 10'd2; tx_byte = 8'hFF; tx_valid = 1;
    tx_start = 1;
    tick();
    tx_start = 0;
    tick();
    tx_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ur_bit", data_sel ? xmit_data[0] : xmit_data[1], 1);
      chk("ur_ready", tx_ready, i == 7);
    end
    tick();
    chk("ur_oe", oe, 0);
    chk("ur_done", done, 1);
    chk("ur_status", status, 2'b11);
    chk("ur_busy", busy, 0);
    tick();
    chk("ur_no_crc_ph", dat_phase, 2'b00);

    // RX start-bit wait with line idle high
    block_len = 10'd1; rcv_data = 2'b11;
    rx_start = 1;
    tick();
    rx_start = 0;
`ifdef SDIO_DAT_SEQ_RX_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("tmo_wait_busy", busy, 1);
      chk("tmo_wait_done", done, 0);
    end
    tick();
    chk("tmo_done", done, 1);
    chk("tmo_status", status, 2'b11);
    chk("tmo_busy", busy, 0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
    end
    abort = 1;
    tick();
    abort = 0;
    chk("wait_abort_done", done, 1);
    chk("wait_abort_status", status, 2'b11);
`endif
    tick();

    // abort mid RX_DATA
    block_len = 10'd2; rcv_data = 2'b11;
    rx_start = 1;
    tick();
    rx_start = 0;
    rcv_data = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      rcv_data = {rcv_data[0], i[0]};
      tick();
    end
    chk("ab_in_data", dat_phase, 2'b10);
    abort = 1;
    tick();
    abort = 0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 1);
    chk("ab_status", status, 2'b11);
    chk("ab_chk_en", crc_check_en, 1);
    rcv_data = 2'b11;
    tick();

    // run a clean RX so status returns to 00 before the next abort
    run_rx(8'h5A, 1'b0, 1'b1, 2'b00);

    // simultaneous tx_start/rx_start: TX wins
    block_len = 10'd1; tx_valid = 0;
    tx_start = 1; rx_start = 1;
    tick();
    tx_start = 0; rx_start = 0;
    chk("both_tx_ready", tx_ready, 1);
    chk("both_not_rx", crc_check_en, 0);
    chk("both_crc_rst", crc_rst, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("both_abort_done", done, 1);
    chk("both_abort_status", status, 2'b11);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sdio_dat_seq.md
# sdio_dat_seq

Data-block sequencer for 1-bit SDIO mode; drives the DAT line stage (`dat1_line`) directly upstream of it. For reads it serializes a block of bytes through start bit, data, CRC16 and end bit. For writes it waits for a start bit, deserializes the received bytes and reports CRC and end-bit status. It generates `dat_phase`, `oe`, `data_sel`, `xmit_data`, `crc_rst` and `crc_check_en`, and consumes `rcv_data` and `crc_error`.

## Interface
- BLK_LEN_W, 10: width of `block_len`; legal length is 1..2^BLK_LEN_W-1 bytes.
- RX_TIMEOUT_W, 16: width of the start-bit wait counter.
- clk  in  1  system clock, same clock as the line stage.
- rst  in  1  asynchronous, active-high reset.
- tx_start / rx_start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  synchronous abort, any state.
- block_len  in  BLK_LEN_W  byte count; sampled when a start is accepted.
- tx_byte  in  8  next byte to transmit; tx_valid in 1, tx_ready out 1.
- rx_byte  out  8  received byte; rx_valid out 1 (one-cycle pulse, no backpressure).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of any transfer.
- status  out  2  valid with `done`: 00 ok, 01 CRC error, 10 end-bit error, 11 timeout/underrun/abort.
- oe, data_sel, crc_rst, crc_check_en  out  1  controls to the line stage.
- dat_phase  out  2  line-stage phase: 00 drive 0, 01 drive 1, 10 data + CRC generate, 11 CRC out/compare.
- xmit_data  out  2  dibit: [1] is the earlier bit, [0] the later bit.
- rcv_data  in  2  sampled line; [0] is the newest bit.
- crc_error  in  1  sticky CRC mismatch from the line stage.

## Operation
- States: IDLE, TX_LOAD, TX_START, TX_DATA, TX_CRC, TX_END, RX_WAIT, RX_DATA, RX_CRC, RX_END.
- Reset and IDLE output values: every output is 0, except `status`, which holds its last value (00 after reset).
- A start request with `block_len`==0 is ignored. If `tx_start` and `rx_start` arrive in the same cycle, tx wins.
- **TX_LOAD**
  - `crc_rst`=1, `tx_ready`=1.
  - Waits indefinitely for `tx_valid`, then loads the byte and moves to TX_START.
- **TX_START**
  - 1 cycle, `oe`=1, `dat_phase`=00 (start bit).
- **TX_DATA**
  - `oe`=1, `dat_phase`=10, for 8*len cycles, MSB first.
  - `data_sel` toggles 0,1,0,1,…; `xmit_data` updates every 2 cycles.
  - `tx_ready`=1 in the last cycle of each non-final byte.
  - If `tx_valid`=0 in that cycle (underrun): go to IDLE, `oe`=0, `done` with status 11.
- **TX_CRC**
  - `oe`=1, `dat_phase`=11, 16 cycles.
- **TX_END**
  - `oe`=1, `dat_phase`=01, 1 cycle; then IDLE with `done` and status 00.
- **RX path**
  - `crc_check_en`=1 from RX_WAIT through the `done` cycle.
  - `crc_rst`=1 in RX_WAIT.
  - `oe`=0 throughout.
- **RX_WAIT**
  - `dat_phase`=00; moves to RX_DATA on `rcv_data[0]`==0.
- **RX_DATA**
  - `dat_phase`=10, 8*len cycles.
  - Shifts `rcv_data[0]` in MSB first; `rx_valid` pulses on the cycle after the 8th bit of each byte.
- **RX_CRC**
  - `dat_phase`=11, 16 cycles.
- **RX_END**
  - 1 cycle; status 01 if `crc_error`, else 10 if `rcv_data[0]`==0, else 00.
  - Then IDLE with `done`.
- **abort**
  - From any state: next cycle is IDLE with `oe`=0 and `done` with status 11.

## Timing
- Start accepted at edge N; TX_LOAD is active from N+1. The first line-stage phase is visible ≥1 cycle after `tx_valid`.
- TX length, from TX_START entry to `done`: 1 + 8*len + 16 + 1 cycles.
- The line stage's internal output pipeline adds its own fixed delay. This block aligns `dat_phase`, `oe` and `xmit_data` in the same cycle and does not compensate for that delay.
- RX: `rcv_data[0]` in the cycle after the start-bit detection is data bit 7 of byte 0.
- `crc_error` is registered by the line stage; the last CRC compare is visible in RX_END.
- `done` and `status` are registered and assert together.
- A second start in the `done` cycle is ignored; the earliest accepted start is one cycle later.

## Configuration
- `SDIO_DAT_SEQ_RX_TIMEOUT_EN` defined:
  - RX_WAIT counts cycles.
  - At 2^RX_TIMEOUT_W-1 cycles without a start bit: go to IDLE, `done` with status 11.
- Undefined:
  - No counter; RX_WAIT exits only on a start bit or `abort`.

## Structure
- Package `sdio_dat_pkg` holds:
  - the state enum;
  - status codes OK/CRC/END/TMO;
  - phase constants DAT_PH_LOW=00, DAT_PH_HIGH=01, DAT_PH_DATA=10, DAT_PH_CRC=11.
- One sub-module, `sdio_dat_shift`:
  - byte serializer/deserializer with a 3-bit bit counter;
  - dibit output and MSB-first capture.
- The FSM, byte counter, CRC-cycle counter and timeout counter stay in the top module.

## Test plan
- TX len=1, byte 0xA5:
  - `dat_phase` sequence: 00(`oe`), then 10×8, then 11×16, then 01.
  - `xmit_data` = 10,10,01,01.
  - Selected bit sequence 1,0,1,0,0,1,0,1.
  - `done` with status 00.
- RX len=1: `rcv_data[0]` = 0, then bits of 0x3C, then correct CRC16, then 1 → `rx_byte`=0x3C with one `rx_valid`, status 00.
- RX with `crc_error` forced high in RX_CRC → status 01. Same with correct CRC but end bit 0 → status 10.
- TX len=2, `tx_valid` low at the end of byte 0 → `oe` low next cycle, status 11, no CRC phase.
- With `SDIO_DAT_SEQ_RX_TIMEOUT_EN` and RX_TIMEOUT_W=4, line held at 1 → `done` after 15 RX_WAIT cycles, status 11. Without the macro: `busy` stays high for 100 cycles.
- `abort` in mid RX_DATA → IDLE next cycle, status 11. `tx_start` and `rx_start` together → TX path taken.
